// File: rtl/sat_block_accumulator.sv
// ---------------------------------------------------------------------------
// sat_block_accumulator
//
// Collects a fixed-length block of signed results from the 4-bit ripple
// adder stage. Each result is added into a wider signed accumulator that
// clamps at its rails. Samples that the adder flagged as overflowed are not
// added; they are counted instead. The finished block is offered downstream
// on a valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      begin a new block (only looked at while idle)
//   clear      synchronous abort: back to idle with all state zeroed
//   in_valid   upstream sample valid
//   in_ready   a sample can be accepted this cycle
//   sum_in     signed adder sum (WIDTH bits)
//   of_in      adder signed-overflow flag for this sample
//   out_valid  block result available
//   out_ready  downstream takes the result
//   acc_out    signed block accumulation (ACC_W bits)
//   of_count   number of samples in the block with of_in=1 (saturating)
//   sat_flag   sticky: accumulator was clamped at least once in the block
// ---------------------------------------------------------------------------
module sat_block_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_W     = 6,
  parameter int BLOCK_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             of_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] of_count,
  output logic             sat_flag
);

  // Enough bits to hold every sample index of the block.
  localparam int SCNT_W = (BLOCK_LEN < 2) ? 1 : $clog2(BLOCK_LEN);
  localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  of_count_reg;
  logic              sat_reg;
  logic [SCNT_W-1:0] scnt_reg;

  logic              accept;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W:0]    add_ext;
  logic [ACC_W:0]    sum_wide;
  logic              pos_ovf;
  logic              neg_ovf;
  logic [ACC_W-1:0]  acc_next;

  assign accept = in_valid & in_ready_reg;

  // The add is done one bit wider than the accumulator; the two top bits of
  // the wide sum disagree exactly when the true result left the ACC_W range,
  // and the top bit alone then gives the direction.
  always_comb begin
    acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    add_ext  = {{(ACC_W + 1 - WIDTH){sum_in[WIDTH-1]}}, sum_in};
    sum_wide = acc_ext + add_ext;
    pos_ovf  = (sum_wide[ACC_W] == 1'b0) && (sum_wide[ACC_W-1] == 1'b1);
    neg_ovf  = (sum_wide[ACC_W] == 1'b1) && (sum_wide[ACC_W-1] == 1'b0);
    acc_next = sum_wide[ACC_W-1:0];
    if (pos_ovf) begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (neg_ovf) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      of_count_reg  <= '0;
      sat_reg       <= 1'b0;
      scnt_reg      <= '0;
    end else if (clear) begin
      // Abort wins over any accept or output handshake in this cycle.
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      of_count_reg  <= '0;
      sat_reg       <= 1'b0;
      scnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= ACC;
            in_ready_reg <= 1'b1;
            acc_reg      <= '0;
            of_count_reg <= '0;
            sat_reg      <= 1'b0;
            scnt_reg     <= '0;
          end
        end

        ACC: begin
          if (accept) begin
            scnt_reg <= scnt_reg + SCNT_W'(1);
            if (of_in) begin
              // Overflowed adder results are counted, never summed.
              if (of_count_reg != {CNT_W{1'b1}}) begin
                of_count_reg <= of_count_reg + CNT_W'(1);
              end
            end else begin
              acc_reg <= acc_next;
              if (pos_ovf || neg_ovf) begin
                sat_reg <= 1'b1;
              end
            end
            if (scnt_reg == LAST_IDX) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign acc_out   = acc_reg;
  assign of_count  = of_count_reg;
  assign sat_flag  = sat_reg;

endmodule

// File: tb/tb_sat_block_accumulator.sv
// ---------------------------------------------------------------------------
// Directed bench for sat_block_accumulator. Inputs change 1 time unit after
// a rising edge and outputs are checked at that same point, so every check
// sees the state registered at the preceding edge.
// ---------------------------------------------------------------------------
module tb_sat_block_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] sum_in;
  logic       of_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] acc_out;
  logic [3:0] of_count;
  logic       sat_flag;

  int checks;
  int errors;

  sat_block_accumulator #(
    .WIDTH(4), .ACC_W(6), .BLOCK_LEN(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in), .of_in(of_in),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
    .of_count(of_count), .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted sample; the block must be in ACC for this to count.
  task automatic feed(input logic [3:0] s, input logic o);
    in_valid = 1'b1;
    sum_in   = s;
    of_in    = o;
    tick();
    in_valid = 1'b0;
    of_in    = 1'b0;
  endtask

  task automatic begin_block();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_block();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    sum_in    = 4'd0;
    of_in     = 1'b0;
    out_ready = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_of_count", of_count, 0);
    chk("rst_sat", sat_flag, 0);
    rst = 1'b0;
    tick();

    // ---- reset mid-block
    begin_block();
    chk("mid_in_ready", in_ready, 1);
    feed(4'd1, 1'b0);
    feed(4'd1, 1'b0);
    feed(4'd1, 1'b0);
    chk("mid_acc3", acc_out, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_acc", acc_out, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    sum_in   = 4'd2;
    tick();
    tick();
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_acc", acc_out, 0);
    in_valid = 1'b0;

    // ---- basic block: 8 x +3
    begin_block();
    for (int i = 0; i < 7; i++) feed(4'b0011, 1'b0);
    chk("basic_acc7", acc_out, 21);
    chk("basic_ov_early", out_valid, 0);
    feed(4'b0011, 1'b0);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_in_ready", in_ready, 0);
    chk("basic_acc", acc_out, 24);
    chk("basic_of_count", of_count, 0);
    chk("basic_sat", sat_flag, 0);
    finish_block();
    chk("basic_idle_ov", out_valid, 0);
    chk("basic_idle_ir", in_ready, 0);
    // in_valid in IDLE must not touch the result
    in_valid = 1'b1;
    sum_in   = 4'd5;
    tick();
    in_valid = 1'b0;
    chk("idle_ignore_acc", acc_out, 24);

    // ---- positive saturation: 8 x +7
    begin_block();
    chk("pos_start_acc", acc_out, 0);
    for (int i = 0; i < 4; i++) feed(4'b0111, 1'b0);
    chk("pos_acc4", acc_out, 28);
    chk("pos_sat4", sat_flag, 0);
    feed(4'b0111, 1'b0);
    chk("pos_acc5", acc_out, 31);
    chk("pos_sat5", sat_flag, 1);
    for (int i = 0; i < 3; i++) feed(4'b0111, 1'b0);
    chk("pos_out_valid", out_valid, 1);
    chk("pos_acc", acc_out, 31);
    chk("pos_sat", sat_flag, 1);
    finish_block();

    // ---- negative saturation: 8 x -8 (new block clears sat)
    begin_block();
    chk("neg_start_sat", sat_flag, 0);
    for (int i = 0; i < 4; i++) feed(4'b1000, 1'b0);
    chk("neg_acc4", acc_out, 6'h20);
    chk("neg_sat4", sat_flag, 0);
    feed(4'b1000, 1'b0);
    chk("neg_acc5", acc_out, 6'h20);
    chk("neg_sat5", sat_flag, 1);
    // one step back off the rail: -32 + 7 = -25
    feed(4'b0111, 1'b0);
    chk("neg_unrail", acc_out, 6'h27);
    chk("neg_sat_sticky", sat_flag, 1);
    feed(4'b1000, 1'b0);
    feed(4'b1000, 1'b0);
    chk("neg_out_valid", out_valid, 1);
    chk("neg_acc", acc_out, 6'h20);
    finish_block();

    // ---- overflow samples, out_ready held high before DONE
    out_ready = 1'b1;
    begin_block();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(4'd5, 1'b0);
      feed(4'b1111, 1'b1);
    end
    feed(4'd5, 1'b0);
    chk("ovf_ov_early", out_valid, 0);
    feed(4'b1010, 1'b1);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_acc", acc_out, 20);
    chk("ovf_of_count", of_count, 4);
    chk("ovf_sat", sat_flag, 0);
    tick();
    chk("ovf_handshake", out_valid, 0);
    out_ready = 1'b0;

    // ---- gaps on in_valid, then back-pressure in DONE
    begin_block();
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      sum_in   = 4'd1;
      tick();
      if (i == 13) begin
        chk("gap_acc7", acc_out, 7);
        chk("gap_ov_early", out_valid, 0);
      end
    end
    in_valid = 1'b0;
    chk("gap_out_valid", out_valid, 1);
    chk("gap_acc", acc_out, 8);
    in_valid = 1'b1;
    sum_in   = 4'd7;
    start    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_acc", acc_out, 8);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    finish_block();
    chk("bp_done_ov", out_valid, 0);

    // ---- clear beats a coincident accept
    begin_block();
    for (int i = 0; i < 5; i++) feed(4'd7, 1'b0);
    feed(4'd3, 1'b1);
    chk("clr_pre_acc", acc_out, 31);
    chk("clr_pre_of", of_count, 1);
    chk("clr_pre_sat", sat_flag, 1);
    clear    = 1'b1;
    in_valid = 1'b1;
    sum_in   = 4'd1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc", acc_out, 0);
    chk("clr_of", of_count, 0);
    chk("clr_sat", sat_flag, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_out_valid", out_valid, 0);
    tick();
    chk("clr_idle_ir", in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
